fifo_n: RTL

FIFO_N -- requirements
Module: fifo_n

---
 rtl/fifo_n_pkg.sv | 16 +
 rtl/fifo_n_if.sv | 23 ++
 rtl/fifo_n.sv | 55 +++++
 3 files changed

// File: rtl/fifo_n_pkg.sv
// Shared definitions for the fifo_n show-ahead queue.
package fifo_n_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_AW    = 2;

  // Per-cycle operation, encoded as {pop_accept, write_accept}.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } op_e;

endpackage

// File: rtl/fifo_n_if.sv
// Producer/consumer bundle for fifo_n; master drives requests, slave is the queue.
interface fifo_n_if #(
  parameter int width = fifo_n_pkg::DEF_WIDTH,
  parameter int aw    = fifo_n_pkg::DEF_AW
);
  logic             addq;
  logic             shiftq;
  logic [width-1:0] indata;
  logic             full;
  logic             empty;
  logic [width-1:0] outdata;
  logic [aw:0]      count;

  modport master (
    output addq, shiftq, indata,
    input  full, empty, outdata, count
  );

  modport slave (
    input  addq, shiftq, indata,
    output full, empty, outdata, count
  );
endinterface

// File: rtl/fifo_n.sv
// Show-ahead FIFO: one storage array plus read/write pointers and an occupancy count.
module fifo_n
  import fifo_n_pkg::*;
#(
  parameter int width = DEF_WIDTH,
  parameter int depth = DEF_DEPTH,
  parameter int aw    = DEF_AW
) (
  input  logic    clk,
  input  logic    reset,
  fifo_n_if.slave q
);

  localparam logic [aw:0] FULL_CNT = (aw+1)'(depth);

  logic [width-1:0] mem [depth];
  logic [aw-1:0]    wr_ptr;
  logic [aw-1:0]    rd_ptr;
  logic [aw:0]      cnt;
  logic             wr_acc;
  logic             rd_acc;
  op_e              op;

  // Flags come only from the registered count, so requests never reach them combinationally.
  assign q.full    = (cnt == FULL_CNT);
  assign q.empty   = (cnt == '0);
  assign q.count   = cnt;
  assign q.outdata = q.empty ? '0 : mem[rd_ptr];

  assign wr_acc = q.addq   && !q.full;
  assign rd_acc = q.shiftq && !q.empty;
  assign op     = op_e'({rd_acc, wr_acc});

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case (op)
        OP_PUSH: cnt <= cnt + 1'b1;
        OP_POP:  cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is never reset; a stale slot is unreachable until rewritten.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= q.indata;
  end

endmodule
